// File: rtl/food_spawner.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | food_spawner: rejection-sampling food placer over a GRID_W x GRID_H grid. |
// | Optional FOOD_RETRY_LIMIT_EN bounds the search to MAX_TRIES rejections.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module food_spawner #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int MAX_TRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] random_num,
  input  logic        spawn_req,
  output logic        occ_req,
  output logic [5:0]  occ_x,
  output logic [4:0]  occ_y,
  input  logic        occ_ack,
  input  logic        occ_hit,
  output logic [5:0]  food_x,
  output logic [4:0]  food_y,
  output logic        food_valid,
  output logic        busy,
  output logic        spawn_fail
);

  if (GRID_W < 1 || GRID_W > 64 || GRID_H < 1 || GRID_H > 32 ||
      MAX_TRIES < 1 || MAX_TRIES > 127) begin : g_bad_params
    $error("food_spawner: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CHECK  = 3'd2,
    QUERY  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [6:0] X_LIMIT = 7'(GRID_W);
  localparam logic [5:0] Y_LIMIT = 6'(GRID_H);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] cand_x;
  logic [4:0] cand_y;
  logic       in_range;
  logic       reject;
  logic       give_up;
  logic       accept;
  logic       unused_rand;

  // Only the x field [5:0] and y field [12:8] of the random word are used.
  assign unused_rand = ^{random_num[15:13], random_num[7:6]};

  assign in_range = ({1'b0, cand_x} < X_LIMIT) && ({1'b0, cand_y} < Y_LIMIT);
  assign accept   = (state == QUERY) && occ_ack && !occ_hit;
  assign reject   = ((state == CHECK) && !in_range) ||
                    ((state == QUERY) && occ_ack && occ_hit);

`ifdef FOOD_RETRY_LIMIT_EN
  localparam logic [6:0] TRY_LIMIT = 7'(MAX_TRIES);

  logic [6:0] tries;
  logic       fail_pulse;

  assign give_up = reject && ((tries + 7'd1) == TRY_LIMIT);

  // Held at zero while idle so every search starts from a clean count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tries      <= 7'd0;
      fail_pulse <= 1'b0;
    end else begin
      fail_pulse <= give_up;
      if (state == IDLE) begin
        tries <= 7'd0;
      end else if (reject) begin
        tries <= tries + 7'd1;
      end
    end
  end

  assign spawn_fail = fail_pulse;
`else
  assign give_up    = 1'b0;
  assign spawn_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (spawn_req) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (in_range) begin
          state_nxt = QUERY;
        end else begin
          state_nxt = give_up ? IDLE : SAMPLE;
        end
      end
      QUERY: begin
        if (occ_ack) begin
          if (occ_hit) begin
            state_nxt = give_up ? IDLE : SAMPLE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Food is written on the accepting edge so it is already valid in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_x <= 6'd0;
      cand_y <= 5'd0;
      food_x <= 6'd0;
      food_y <= 5'd0;
    end else begin
      if (state == SAMPLE) begin
        cand_x <= random_num[5:0];
        cand_y <= random_num[12:8];
      end
      if (accept) begin
        food_x <= cand_x;
        food_y <= cand_y;
      end
    end
  end

  assign occ_req    = (state == QUERY);
  assign occ_x      = cand_x;
  assign occ_y      = cand_y;
  assign food_valid = (state == DONE);
  assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_food_spawner.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_food_spawner: randomized scoreboard bench for food_spawner.            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_food_spawner;
  localparam int GRID_W    = 40;
  localparam int GRID_H    = 30;
  localparam int MAX_TRIES = 4;
  localparam int NCYC      = 16384;
`ifdef FOOD_RETRY_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] random_num = 16'd0;
  logic        spawn_req = 1'b0;
  logic        occ_ack = 1'b0;
  logic        occ_hit = 1'b0;
  logic        occ_req;
  logic [5:0]  occ_x;
  logic [4:0]  occ_y;
  logic [5:0]  food_x;
  logic [4:0]  food_y;
  logic        food_valid;
  logic        busy;
  logic        spawn_fail;

  food_spawner #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst_n(rst_n), .random_num(random_num), .spawn_req(spawn_req),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack),
    .occ_hit(occ_hit), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .busy(busy), .spawn_fail(spawn_fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int x; int y; int c; } ev_t;
  ev_t  food_q[$];
  ev_t  qry_q[$];
  int   fail_q[$];
  int   dly_q[$];
  int   dly_force[$];
  logic [15:0] rn [NCYC];
  bit   occ_map [64][32];
  bit   all_hit = 1'b0;
  bit   free_q = 1'b0;
  int   idle_edge = 0;
  int   bs = 1;
  int   be = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void chk(int act, int exp, string nm);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: a request accepted at edge e captures a fresh word every
  // SAMPLE; a range reject costs two edges, a query d+1 edges after CHECK.
  task automatic plan(input int e);
    int t, rej, x, y, d, a;
    bit hit;
    t = e + 1; rej = 0; bs = e;
    for (int it = 0; it < 200 && t < NCYC - 2; it++) begin
      x = int'(rn[t][5:0]);
      y = int'(rn[t][12:8]);
      if (x >= GRID_W || y >= GRID_H) begin
        rej++;
        if (LIMIT_ON && rej == MAX_TRIES) begin
          fail_q.push_back(t + 1); idle_edge = t + 2; be = t; return;
        end
        t += 2;
      end else begin
        if (dly_force.size() > 0) d = dly_force.pop_front();
        else d = int'($urandom_range(0, 3));
        dly_q.push_back(d);
        qry_q.push_back('{x, y, t + 1});
        hit = all_hit || occ_map[x][y];
        a = t + 2 + d;
        if (hit) begin
          rej++;
          if (LIMIT_ON && rej == MAX_TRIES) begin
            fail_q.push_back(a); idle_edge = a + 1; be = a - 1; return;
          end
          t = a + 1;
        end else begin
          food_q.push_back('{x, y, a}); idle_edge = a + 2; be = a; return;
        end
      end
    end
    idle_edge = t; be = t;
  endtask

  // Occupancy tracker: answers each query after its planned delay.
  initial begin
    bit prev;
    int cnt;
    prev = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
        continue;
      end
      if (occ_req) begin
        if (!prev) cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
        occ_ack = (cnt == 0);
        occ_hit = all_hit || occ_map[occ_x][occ_y];
        cnt--;
      end else begin
        occ_ack = 1'($urandom_range(0, 3) == 0);
        occ_hit = 1'($urandom_range(0, 1));
      end
      prev = occ_req;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    bit prev;
    ev_t cur, ev;
    prev = 1'b0;
    cur = '{-1, -1, -1};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        continue;
      end
      chk(int'(busy), int'(cyc >= bs && cyc <= be), "busy");
      if (occ_req && !free_q) begin
        if (!prev) begin
          if (qry_q.size() == 0) begin
            chk(int'(occ_req), 0, "occ_req_unexpected");
            cur = '{-1, -1, -1};
          end else begin
            cur = qry_q.pop_front();
            chk(cyc, cur.c, "query_cycle");
          end
        end
        chk(int'(occ_x), cur.x, "occ_x");
        chk(int'(occ_y), cur.y, "occ_y");
      end
      prev = occ_req;
      if (food_valid) begin
        if (food_q.size() == 0) begin
          chk(int'(food_valid), 0, "food_valid_unexpected");
        end else begin
          ev = food_q.pop_front();
          chk(int'(food_x), ev.x, "food_x");
          chk(int'(food_y), ev.y, "food_y");
          chk(cyc, ev.c, "food_cycle");
        end
      end
      if (spawn_fail) begin
        if (fail_q.size() == 0) chk(int'(spawn_fail), 0, "spawn_fail_unexpected");
        else chk(cyc, fail_q.pop_front(), "spawn_fail_cycle");
      end
    end
  end

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic step();
    @(negedge clk); #1;
    if (cyc > NCYC - 400) begin
      n_fail++;
      $display("FAIL timeout: cycle budget exhausted at cycle %0d", cyc);
      summary_and_finish();
    end
    random_num = rn[cyc + 1];
    spawn_req  = (cyc + 1 < idle_edge) ? 1'($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  task automatic wait_idle();
    step();
    while (cyc + 1 < idle_edge) step();
  endtask

  task automatic issue();
    spawn_req = 1'b1;
    plan(cyc + 1);
  endtask

  task automatic fill(input int from, input int to, input logic [15:0] v);
    for (int i = from; i <= to; i++) rn[i] = v;
  endtask

  initial begin
    int e;
    bit seen;
    for (int i = 0; i < NCYC; i++) rn[i] = 16'($urandom);
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++) occ_map[x][y] = ($urandom_range(0, 3) == 0);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk(int'(food_x), 0, "reset_food_x");
    chk(int'(food_y), 0, "reset_food_y");
    chk(int'(food_valid), 0, "reset_food_valid");
    chk(int'(busy), 0, "reset_busy");
    chk(int'(occ_req), 0, "reset_occ_req");
    chk(int'(spawn_fail), 0, "reset_spawn_fail");
    rst_n = 1'b1;
    idle_edge = cyc + 1;

    // Minimum-latency spawn at (5,10).
    wait_idle(); e = cyc + 1;
    fill(e + 1, e + 30, 16'h0A05);
    occ_map[5][10] = 1'b0;
    dly_force.push_back(0);
    issue();

    // Three out-of-range samples, then (2,1).
    wait_idle(); e = cyc + 1;
    fill(e + 1, e + 6, 16'h003F);
    fill(e + 7, e + 40, 16'h0102);
    occ_map[2][1] = 1'b0;
    dly_force.push_back(0);
    issue();

    // Occupied (5,10), then free (7,3) with a slow answer.
    wait_idle(); e = cyc + 1;
    rn[e + 1] = 16'h0A05;
    fill(e + 2, e + 40, 16'h0307);
    occ_map[5][10] = 1'b1;
    occ_map[7][3]  = 1'b0;
    dly_force.push_back(0);
    dly_force.push_back(5);
    issue();

    // Reset while a query is outstanding.
    wait_idle(); e = cyc + 1;
    fill(e + 1, e + 30, 16'h0A05);
    occ_map[5][10] = 1'b0;
    dly_force.push_back(10);
    issue();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = occ_req;
    end
    chk(int'(occ_req), 1, "occ_req_seen");
    step();
    rst_n = 1'b0;
    food_q.delete(); qry_q.delete(); dly_q.delete(); fail_q.delete();
    bs = 1; be = 0;
    step();
    chk(int'(occ_req), 0, "rst_mid_occ_req");
    chk(int'(busy), 0, "rst_mid_busy");
    chk(int'(food_valid), 0, "rst_mid_food_valid");
    chk(int'(food_x), 0, "rst_mid_food_x");
    chk(int'(food_y), 0, "rst_mid_food_y");
    rst_n = 1'b1; spawn_req = 1'b0;
    idle_edge = cyc + 1;
    repeat (5) step();

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      wait_idle();
      if ($urandom_range(0, 9) == 0)
        for (int x = 0; x < 64; x++)
          for (int y = 0; y < 32; y++) occ_map[x][y] = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) step();
      issue();
    end

    // Every cell occupied.
    wait_idle();
    all_hit = 1'b1;
`ifdef FOOD_RETRY_LIMIT_EN
    issue();
    wait_idle();
    repeat (3) step();
`else
    free_q = 1'b1;
    bs = cyc + 1; be = NCYC * 4;
    spawn_req = 1'b1;
    idle_edge = NCYC * 4;
    repeat (60) step();
    rst_n = 1'b0;
    bs = 1; be = 0;
    repeat (2) step();
    rst_n = 1'b1; spawn_req = 1'b0;
    free_q = 1'b0;
    idle_edge = cyc + 1;
`endif
    all_hit = 1'b0;
    repeat (5) step();

    chk(food_q.size(), 0, "food_pending");
    chk(qry_q.size(), 0, "query_pending");
    chk(fail_q.size(), 0, "spawn_fail_pending");
    summary_and_finish();
  end
endmodule
`default_nettype wire
